// File: rtl/muldiv_arbiter_if.sv
// muldiv_arbiter_if: request, response and unit-side signals of the shared M-extension arbiter.
interface muldiv_arbiter_if;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [2:0]  req0_funct3, req1_funct3;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        flush;
    logic [31:0] md_op1, md_op2;
    logic [7:0]  md_op;
    logic        md_we;
    logic [31:0] md_wdata;
    modport slave (
        input  req0_valid, req1_valid, req0_op1, req0_op2, req1_op1, req1_op2,
               req0_funct3, req1_funct3, flush, md_we, md_wdata,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err,
               md_op1, md_op2, md_op
    );
    modport master (
        output req0_valid, req1_valid, req0_op1, req0_op2, req1_op1, req1_op2,
               req0_funct3, req1_funct3, flush, md_we, md_wdata,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err,
               md_op1, md_op2, md_op
    );
endinterface

// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter: round-robin sharing of one mul/div unit between two requesters.
// Define MULDIV_ARB_TIMEOUT_EN to enable the busy watchdog (TIMEOUT_CYC cycles).
module muldiv_arbiter #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    muldiv_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, RESP} state_t;
    state_t      state, next;
    logic [31:0] op1, op2, res;
    logic [2:0]  f3;
    logic        owner, last, err;
    logic        gnt0, gnt1, acc0, acc1, timeout, pulse0, pulse1;
`ifdef MULDIV_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (state == IDLE) cnt <= '0;
        else if (state == BUSY || state == DRAIN) cnt <= cnt + 1'b1;
    assign timeout = (state == BUSY || state == DRAIN) && cnt == CW'(TIMEOUT_CYC - 1);
`else
    assign timeout = 1'b0;
`endif
    assign gnt1 = bus.req1_valid && (!bus.req0_valid || !last);
    assign gnt0 = bus.req0_valid && !gnt1;
    assign acc0 = state == IDLE && !bus.flush && gnt0;
    assign acc1 = state == IDLE && !bus.flush && gnt1;
    assign bus.req0_ready = acc0;
    assign bus.req1_ready = acc1;
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = (acc0 || acc1) ? BUSY : IDLE;
            BUSY:    next = (bus.flush && !owner) ? (bus.md_we ? IDLE : DRAIN)
                          : (bus.md_we || timeout) ? RESP : BUSY;
            DRAIN:   next = (bus.md_we || timeout) ? IDLE : DRAIN;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            op1   <= '0;
            op2   <= '0;
            f3    <= '0;
            owner <= 1'b0;
            last  <= 1'b1;
            res   <= '0;
            err   <= 1'b0;
        end else begin
            state <= next;
            if (acc0 || acc1) begin
                op1   <= acc1 ? bus.req1_op1 : bus.req0_op1;
                op2   <= acc1 ? bus.req1_op2 : bus.req0_op2;
                f3    <= acc1 ? bus.req1_funct3 : bus.req0_funct3;
                owner <= acc1;
                last  <= acc1;
            end
            // A watchdog exit reaches RESP without md_we, which is what flags the error
            if (state == BUSY && next == RESP) begin
                res <= bus.md_we ? bus.md_wdata : 32'd0;
                err <= !bus.md_we;
            end
        end
    assign pulse0 = state == RESP && !owner && !bus.flush;
    assign pulse1 = state == RESP && owner;
    assign bus.rsp0_valid = pulse0;
    assign bus.rsp1_valid = pulse1;
    assign bus.rsp_data   = (pulse0 || pulse1) ? res : 32'd0;
    assign bus.rsp_err    = (pulse0 || pulse1) && err;
    assign bus.md_op1     = op1;
    assign bus.md_op2     = op2;
    assign bus.md_op      = (state == BUSY || state == DRAIN) ? 8'(8'h01 << f3) : 8'h00;
endmodule

// File: tb/tb_muldiv_arbiter.sv
// tb_muldiv_arbiter: directed checks of grant order, latency, flush/drain and reset behaviour.
module tb_muldiv_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    muldiv_arbiter_if bus();
    muldiv_arbiter #(.TIMEOUT_CYC(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
    task automatic step;
        @(negedge clk);
    endtask
    task automatic idle_inputs;
        bus.req0_valid = 0; bus.req1_valid = 0; bus.flush = 0; bus.md_we = 0; bus.md_wdata = 0;
        bus.req0_op1 = 0; bus.req0_op2 = 0; bus.req0_funct3 = 0;
        bus.req1_op1 = 0; bus.req1_op2 = 0; bus.req1_funct3 = 0;
    endtask
    task automatic do_reset;
        idle_inputs();
        rst_n = 0;
        repeat (2) step();
        rst_n = 1;
    endtask
    task automatic test_reset;
        idle_inputs();
        rst_n = 0;
        #1;
        checks++; if (bus.md_op !== 8'h00) begin errors++; $display("FAIL reset_md_op got=%h exp=00", bus.md_op); end
        checks++; if (bus.md_op1 !== 32'd0 || bus.md_op2 !== 32'd0) begin errors++; $display("FAIL reset_md_ops got=%h/%h exp=0/0", bus.md_op1, bus.md_op2); end
        checks++; if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err, bus.req0_ready, bus.req1_ready} !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b exp=00000", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err, bus.req0_ready, bus.req1_ready}); end
        checks++; if (bus.rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); end
        repeat (2) step();
        rst_n = 1;
    endtask
    task automatic test_mul;
        step(); bus.req0_valid = 1; bus.req0_op1 = 7; bus.req0_op2 = 6; bus.req0_funct3 = 3'd0; #1;
        checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL mul_ready got=%b%b exp=10", bus.req0_ready, bus.req1_ready); end
        step(); bus.req0_valid = 0; bus.md_we = 1; bus.md_wdata = 42; #1;
        checks++; if (bus.md_op !== 8'h01) begin errors++; $display("FAIL mul_md_op got=%h exp=01", bus.md_op); end
        checks++; if (bus.md_op1 !== 32'd7 || bus.md_op2 !== 32'd6) begin errors++; $display("FAIL mul_operands got=%0d/%0d exp=7/6", bus.md_op1, bus.md_op2); end
        step(); bus.md_we = 0; #1;
        checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0) begin errors++; $display("FAIL mul_rsp_valid got=%b%b exp=10", bus.rsp0_valid, bus.rsp1_valid); end
        checks++; if (bus.rsp_data !== 32'd42 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL mul_rsp_data got=%0d err=%b exp=42 err=0", bus.rsp_data, bus.rsp_err); end
        checks++; if (bus.md_op !== 8'h00) begin errors++; $display("FAIL mul_resp_md_op got=%h exp=00", bus.md_op); end
        step(); #1;
        checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp_data !== 32'd0) begin errors++; $display("FAIL mul_pulse_end got=%b/%h exp=0/0", bus.rsp0_valid, bus.rsp_data); end
    endtask
    task automatic test_tie;
        do_reset();
        step(); bus.req0_valid = 1; bus.req1_valid = 1; #1;
        checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL tie_first got=%b%b exp=10", bus.req0_ready, bus.req1_ready); end
        step(); bus.req0_valid = 0; bus.md_we = 1; bus.md_wdata = 5;
        step(); bus.md_we = 0; #1;
        checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp_data !== 32'd5) begin errors++; $display("FAIL tie_rsp0 got=%b/%0d exp=1/5", bus.rsp0_valid, bus.rsp_data); end
        step(); #1;
        checks++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin errors++; $display("FAIL tie_second got=%b%b exp=01", bus.req0_ready, bus.req1_ready); end
        step(); bus.req1_valid = 0; bus.md_we = 1; bus.md_wdata = 9;
        step(); bus.md_we = 0; #1;
        checks++; if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp_data !== 32'd9) begin errors++; $display("FAIL tie_rsp1 got=%b%b/%0d exp=01/9", bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data); end
        step(); bus.req0_valid = 1; bus.req1_valid = 1; #1;
        checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL tie_alt0 got=%b%b exp=10", bus.req0_ready, bus.req1_ready); end
        step(); bus.req0_valid = 0; bus.md_we = 1;
        step(); bus.md_we = 0;
        step(); bus.req0_valid = 1; #1;
        checks++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin errors++; $display("FAIL tie_alt1 got=%b%b exp=01", bus.req0_ready, bus.req1_ready); end
        step(); bus.req0_valid = 0; bus.req1_valid = 0; bus.md_we = 1;
        step(); bus.md_we = 0;
        step();
    endtask
    task automatic test_div_overflow;
        int bad = 0;
        bus.req1_valid = 1; bus.req1_op1 = 32'h8000_0000; bus.req1_op2 = 32'hFFFF_FFFF; bus.req1_funct3 = 3'd4; #1;
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL div_ready got=%b exp=1", bus.req1_ready); end
        for (int i = 0; i < 32; i++) begin
            step(); bus.req1_valid = 0; #1;
            if (bus.md_op !== 8'h10 || bus.md_op1 !== 32'h8000_0000 || bus.md_op2 !== 32'hFFFF_FFFF || bus.rsp1_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL div_hold got=%0d bad cycles exp=0", bad); end
        step(); bus.md_we = 1; bus.md_wdata = 32'h8000_0000; #1;
        checks++; if (bus.md_op !== 8'h10) begin errors++; $display("FAIL div_we_cycle_op got=%h exp=10", bus.md_op); end
        step(); bus.md_we = 0; #1;
        checks++; if (bus.rsp1_valid !== 1'b1 || bus.rsp_data !== 32'h8000_0000) begin errors++; $display("FAIL div_rsp got=%b/%h exp=1/80000000", bus.rsp1_valid, bus.rsp_data); end
        step();
    endtask
    task automatic test_flush_drain;
        int bad = 0;
        bus.req0_valid = 1; bus.req0_op1 = 100; bus.req0_op2 = 7; bus.req0_funct3 = 3'd5; #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL drain_accept got=%b exp=1", bus.req0_ready); end
        for (int i = 0; i < 4; i++) begin
            step(); bus.req0_valid = 0; bus.req1_valid = 1; bus.req1_op1 = 3; bus.req1_op2 = 3; bus.req1_funct3 = 3'd0; #1;
            if (bus.md_op !== 8'h20 || bus.req1_ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL drain_busy got=%0d bad cycles exp=0", bad); end
        step(); bus.flush = 1; #1;
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL drain_busy_ready got=%b exp=0", bus.req1_ready); end
        step(); bus.flush = 0; #1;
        checks++; if (bus.md_op !== 8'h20 || bus.rsp0_valid !== 1'b0) begin errors++; $display("FAIL drain_hold got=%h/%b exp=20/0", bus.md_op, bus.rsp0_valid); end
        step(); bus.md_we = 1; bus.md_wdata = 14;
        step(); bus.md_we = 0; #1;
        checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp_data !== 32'd0 || bus.md_op !== 8'h00) begin errors++; $display("FAIL drain_discard got=%b/%h/%h exp=0/0/00", bus.rsp0_valid, bus.rsp_data, bus.md_op); end
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL drain_next_grant got=%b exp=1", bus.req1_ready); end
        step(); bus.req1_valid = 0; bus.md_we = 1; bus.md_wdata = 9;
        step(); bus.md_we = 0; #1;
        checks++; if (bus.rsp1_valid !== 1'b1 || bus.rsp_data !== 32'd9) begin errors++; $display("FAIL drain_rsp1 got=%b/%0d exp=1/9", bus.rsp1_valid, bus.rsp_data); end
        step();
    endtask
    task automatic test_flush_we;
        bus.req0_valid = 1; bus.req0_op1 = 2; bus.req0_op2 = 3; bus.req0_funct3 = 3'd0;
        step(); bus.req0_valid = 0; bus.md_we = 1; bus.flush = 1; bus.md_wdata = 77;
        step(); bus.md_we = 0; bus.flush = 0; #1;
        checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp_data !== 32'd0 || bus.md_op !== 8'h00) begin errors++; $display("FAIL flushwe_drop got=%b/%h/%h exp=0/0/00", bus.rsp0_valid, bus.rsp_data, bus.md_op); end
        bus.flush = 1; bus.req0_valid = 1; #1;
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL flush_blocks_ready got=%b exp=0", bus.req0_ready); end
        bus.flush = 0; #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL flushwe_idle_ready got=%b exp=1", bus.req0_ready); end
        step(); bus.req0_valid = 0; bus.md_we = 1; bus.md_wdata = 6;
        step(); bus.md_we = 0; bus.flush = 1; #1;
        checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp_data !== 32'd0) begin errors++; $display("FAIL flush_resp_suppress got=%b/%h exp=0/0", bus.rsp0_valid, bus.rsp_data); end
        step(); bus.flush = 0; bus.req1_valid = 1; bus.req1_op1 = 5; bus.req1_op2 = 11; bus.req1_funct3 = 3'd0; #1;
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL flush_owner1_accept got=%b exp=1", bus.req1_ready); end
        step(); bus.req1_valid = 0; bus.flush = 1; bus.md_we = 1; bus.md_wdata = 55;
        step(); bus.md_we = 0; #1;
        checks++; if (bus.rsp1_valid !== 1'b1 || bus.rsp_data !== 32'd55) begin errors++; $display("FAIL flush_owner1_rsp got=%b/%0d exp=1/55", bus.rsp1_valid, bus.rsp_data); end
        bus.flush = 0;
        step();
    endtask
    task automatic test_midreset;
        bus.req1_valid = 1; bus.req1_funct3 = 3'd1; bus.req1_op1 = 4; bus.req1_op2 = 4; #1;
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL midrst_accept got=%b exp=1", bus.req1_ready); end
        step(); bus.req1_valid = 0; #1;
        checks++; if (bus.md_op !== 8'h02) begin errors++; $display("FAIL midrst_busy_op got=%h exp=02", bus.md_op); end
        rst_n = 0; #1;
        checks++; if (bus.md_op !== 8'h00 || bus.md_op1 !== 32'd0) begin errors++; $display("FAIL midrst_async got=%h/%h exp=00/0", bus.md_op, bus.md_op1); end
        step(); rst_n = 1; bus.md_we = 1; bus.md_wdata = 3;
        step(); bus.md_we = 0; #1;
        checks++; if (bus.rsp1_valid !== 1'b0 || bus.rsp0_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp got=%b%b exp=00", bus.rsp0_valid, bus.rsp1_valid); end
        step();
    endtask
`ifdef MULDIV_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int bad = 0;
        bus.req0_valid = 1; bus.req0_funct3 = 3'd0; bus.req0_op1 = 1; bus.req0_op2 = 1;
        for (int i = 0; i < 8; i++) begin
            step(); bus.req0_valid = 0; #1;
            if (bus.rsp0_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL timeout_early got=%0d exp=0", bad); end
        step(); #1;
        checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'd0) begin errors++; $display("FAIL timeout_rsp got=%b/%b/%h exp=1/1/0", bus.rsp0_valid, bus.rsp_err, bus.rsp_data); end
        step();
    endtask
`endif
    initial begin
        test_reset();
        test_mul();
        test_tie();
        test_div_overflow();
        test_flush_drain();
        test_flush_we();
        test_midreset();
`ifdef MULDIV_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
